// File: rtl/dcache_pkg.sv
// Shared types and constants for the byte-serial data cache front end.
package dcache_pkg;

  // Default memory address width in bits.
  localparam int unsigned ADD_W = 32;

  // Access sizes in bytes.
  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    DONE = 2'd2
  } state_t;

  // Any size other than byte/half/word is handled as a full word.
  function automatic logic [2:0] len_fix(input logic [2:0] len);
    case (len)
      LEN_B, LEN_H, LEN_W: len_fix = len;
      default:             len_fix = LEN_W;
    endcase
  endfunction

endpackage

// File: rtl/dcache_if.sv
// LSB request/response, ROB flush and byte-wide memory bus signals for dcache.
interface dcache_if #(
  parameter int unsigned ADD_W = dcache_pkg::ADD_W
) ();

  logic             iLSB_En;
  logic             iLSB_Rw;
  logic [2:0]       iLSB_Len;
  logic [ADD_W-1:0] iLSB_Add;
  logic [31:0]      iLSB_Dat;
  logic             oLSB_En;
  logic [31:0]      oLSB_Dat;
  logic             iROB_Mp;
  logic             oMEM_Req;
  logic             iMEM_Gnt;
  logic [ADD_W-1:0] oMEM_A;
  logic             oMEM_Wr;
  logic [7:0]       oMEM_Dout;
  logic [7:0]       iMEM_Din;

  // Cache side.
  modport slave (
    input  iLSB_En, iLSB_Rw, iLSB_Len, iLSB_Add, iLSB_Dat, iROB_Mp, iMEM_Gnt, iMEM_Din,
    output oLSB_En, oLSB_Dat, oMEM_Req, oMEM_A, oMEM_Wr, oMEM_Dout
  );

  // Requester / memory side.
  modport master (
    output iLSB_En, iLSB_Rw, iLSB_Len, iLSB_Add, iLSB_Dat, iROB_Mp, iMEM_Gnt, iMEM_Din,
    input  oLSB_En, oLSB_Dat, oMEM_Req, oMEM_A, oMEM_Wr, oMEM_Dout
  );

endinterface

// File: rtl/dcache_rdbuf.sv
// One-entry word read buffer: holds the last aligned word read, dropped on any
// write byte landing in that word. Only built when DCACHE_RDBUF_EN is defined.
module dcache_rdbuf #(
  parameter int unsigned ADD_W = dcache_pkg::ADD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [ADD_W-3:0] look_tag_i,
  output logic             hit_o,
  output logic [31:0]      rd_data_o,
  input  logic             fill_i,
  input  logic [ADD_W-3:0] fill_tag_i,
  input  logic [31:0]      fill_data_i,
  input  logic             wr_i,
  input  logic [ADD_W-3:0] wr_tag_i
);

  logic             valid_q;
  logic [ADD_W-3:0] tag_q;
  logic [31:0]      data_q;

  // Fill on completed aligned word reads, invalidate on overlapping write bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      data_q  <= '0;
    end else if (en_i) begin
      if (fill_i) begin
        valid_q <= 1'b1;
        tag_q   <= fill_tag_i;
        data_q  <= fill_data_i;
      end else if (wr_i && (wr_tag_i == tag_q)) begin
        valid_q <= 1'b0;
      end
    end
  end

  // Lookup is purely combinational so a hit can complete straight from IDLE.
  always_comb begin
    hit_o     = valid_q && (look_tag_i == tag_q);
    rd_data_o = data_q;
  end

endmodule

// File: rtl/dcache.sv
// Byte-serial data cache front end: turns 1/2/4-byte LSB loads and stores into
// a sequence of single-byte memory bus accesses. Optional read buffer is
// enabled with the DCACHE_RDBUF_EN macro.
module dcache
  import dcache_pkg::*;
#(
  parameter int unsigned ADD_W = dcache_pkg::ADD_W
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    en,
  dcache_if.slave bus
);

  state_t           st_q, st_d;
  logic [2:0]       k_q;
  logic             rw_q;
  logic [2:0]       len_q;
  logic [ADD_W-1:0] add_q;
  logic [31:0]      dat_q;
  logic [31:0]      res_q;
  logic             pend_q;      // a read byte was issued last cycle
  logic [1:0]       pend_idx_q;  // which result byte it belongs to

  logic [2:0]       len_in;
  logic [ADD_W-1:0] mem_a;
  logic             issue, cap, flush, last_wr, last_rd, hit_now;
  logic             buf_hit;
  logic [31:0]      buf_data;

  assign len_in  = len_fix(bus.iLSB_Len);
  assign mem_a   = add_q + ADD_W'(k_q);
  // A byte goes out on every enabled, granted XFER cycle until all are issued.
  assign issue   = en && (st_q == XFER) && bus.iMEM_Gnt && (k_q < len_q);
  // Read data returns one cycle after issue, whatever the grant is now.
  assign cap     = en && (st_q == XFER) && pend_q;
  assign flush   = (st_q == XFER) && !rw_q && bus.iROB_Mp;
  assign last_wr = issue && rw_q && ((k_q + 3'd1) == len_q);
  assign last_rd = cap && (({1'b0, pend_idx_q} + 3'd1) == len_q);
  assign hit_now = buf_hit && !bus.iLSB_Rw && (len_in == LEN_W) && (bus.iLSB_Add[1:0] == 2'b00);

`ifdef DCACHE_RDBUF_EN
  logic buf_fill, buf_wr;

  assign buf_fill = en && (st_q == DONE) && !rw_q && (len_q == LEN_W) && (add_q[1:0] == 2'b00);
  assign buf_wr   = issue && rw_q;

  dcache_rdbuf #(
    .ADD_W (ADD_W)
  ) u_rdbuf (
    .clk         (clk),
    .rst         (rst),
    .en_i        (en),
    .look_tag_i  (bus.iLSB_Add[ADD_W-1:2]),
    .hit_o       (buf_hit),
    .rd_data_o   (buf_data),
    .fill_i      (buf_fill),
    .fill_tag_i  (add_q[ADD_W-1:2]),
    .fill_data_i (res_q),
    .wr_i        (buf_wr),
    .wr_tag_i    (mem_a[ADD_W-1:2])
  );
`else
  assign buf_hit  = 1'b0;
  assign buf_data = '0;
`endif

  // State register; reset wins over enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
    end else if (en) begin
      st_q <= st_d;
    end
  end

  // Next-state logic.
  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE: if (bus.iLSB_En) st_d = hit_now ? DONE : XFER;
      XFER: begin
        if (flush) begin
          st_d = IDLE;
        end else if (last_wr || last_rd) begin
          st_d = DONE;
        end
      end
      DONE:    st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  // Request latch, byte index and read assembly.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_q        <= '0;
      rw_q       <= 1'b0;
      len_q      <= '0;
      add_q      <= '0;
      dat_q      <= '0;
      res_q      <= '0;
      pend_q     <= 1'b0;
      pend_idx_q <= '0;
    end else if (en) begin
      case (st_q)
        IDLE: begin
          if (bus.iLSB_En) begin
            rw_q   <= bus.iLSB_Rw;
            len_q  <= len_in;
            add_q  <= bus.iLSB_Add;
            dat_q  <= bus.iLSB_Dat;
            k_q    <= '0;
            pend_q <= 1'b0;
            // Clearing here keeps bytes above Len at zero.
            res_q  <= hit_now ? buf_data : '0;
          end
        end
        XFER: begin
          if (flush) begin
            k_q    <= '0;
            pend_q <= 1'b0;
          end else begin
            pend_q <= issue && !rw_q;
            if (issue) begin
              k_q        <= k_q + 3'd1;
              pend_idx_q <= k_q[1:0];
            end
            if (cap) res_q[{pend_idx_q, 3'b000} +: 8] <= bus.iMEM_Din;
          end
        end
        default: begin
          k_q    <= '0;
          pend_q <= 1'b0;
        end
      endcase
    end
  end

  // Outputs decoded from state and latched request.
  always_comb begin
    bus.oMEM_Req  = (st_q == XFER);
    bus.oMEM_Wr   = issue && rw_q;
    bus.oMEM_A    = (st_q == XFER) ? mem_a : '0;
    bus.oMEM_Dout = (issue && rw_q) ? dat_q[{k_q[1:0], 3'b000} +: 8] : 8'h00;
    bus.oLSB_En   = (st_q == DONE);
    bus.oLSB_Dat  = (st_q == DONE) ? res_q : 32'h0;
  end

endmodule

// File: tb/tb_dcache.sv
// Self-checking bench for dcache against a transaction-level model of memory
// and of the optional read buffer (DCACHE_RDBUF_EN).
module tb_dcache;
  import dcache_pkg::*;

`ifdef DCACHE_RDBUF_EN
  localparam bit RDBUF = 1'b1;
`else
  localparam bit RDBUF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, en;
  dcache_if #(.ADD_W(32)) bus ();

  dcache #(.ADD_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Byte memory behind the bus (4 KiB image, address wraps on low 12 bits).
  bit   [7:0] mem     [4096];
  bit   [7:0] ref_mem [4096];
  logic [7:0] din_r;

  always @(posedge clk) begin
    if (bus.oMEM_Wr === 1'b1) mem[bus.oMEM_A[11:0]] <= bus.oMEM_Dout;
    din_r <= mem[bus.oMEM_A[11:0]];
  end
  assign bus.iMEM_Din = din_r;

  int nvec = 0;
  int nerr = 0;

  // Read buffer model.
  bit          bvalid = 1'b0;
  logic [29:0] btag   = '0;

  task automatic idle_inputs;
    bus.iLSB_En  = 1'b0;
    bus.iLSB_Rw  = 1'b0;
    bus.iLSB_Len = 3'd0;
    bus.iLSB_Add = '0;
    bus.iLSB_Dat = '0;
    bus.iROB_Mp  = 1'b0;
    bus.iMEM_Gnt = 1'b0;
  endtask

  task automatic model_write(input logic [31:0] add, input int n, input logic [31:0] dat);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = add + i;
      ref_mem[a[11:0]] = dat[8*i +: 8];
      if (a[31:2] == btag) bvalid = 1'b0;
    end
  endtask

  // One LSB transaction issued in cycle 0. gmask bit c is the grant in cycle c
  // (grant is 1 from cycle 32 on). mp_req: -1 none, 0 random cycle, >0 exact.
  task automatic txn(input bit rw, input logic [2:0] len_raw, input logic [31:0] add,
                     input logic [31:0] dat, input logic [31:0] gmask, input int mp_req,
                     input bit junk, input string name);
    int len, done, t, cnt, mp_cyc, ncyc, en_cnt, en_cyc, req_cnt, nz, nev;
    bit hit, dropped, g;
    logic [31:0] exp, rdat, a;
    logic [31:0] ev_a [8];
    logic [7:0]  ev_d [8];

    len = (len_raw == 3'd1 || len_raw == 3'd2 || len_raw == 3'd4) ? int'(len_raw) : 4;
    hit = RDBUF && !rw && len == 4 && add[1:0] == 2'b00 && bvalid && btag == add[31:2];
    exp = '0;
    for (int i = 0; i < len; i++) begin
      a = add + i;
      exp[8*i +: 8] = ref_mem[a[11:0]];
    end
    if (hit) begin
      done = 1;
    end else begin
      cnt = 0;
      t = 0;
      for (int c = 1; c < 200 && t == 0; c++) begin
        g = (c < 32) ? gmask[c] : 1'b1;
        if (g) cnt++;
        if (cnt == len) t = c;
      end
      done = t + (rw ? 1 : 2);
    end
    mp_cyc = -1;
    if (!hit && mp_req == 0) mp_cyc = int'($urandom_range(1, done - 1));
    else if (!hit && mp_req > 0) mp_cyc = mp_req;
    dropped = !rw && !hit && mp_cyc >= 1 && mp_cyc < done;
    ncyc = dropped ? mp_cyc + 3 : done + 2;

    en_cnt = 0; en_cyc = -1; req_cnt = 0; nz = 0; nev = 0; rdat = '0;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        bus.iLSB_En  = 1'b1;
        bus.iLSB_Rw  = rw;
        bus.iLSB_Len = len_raw;
        bus.iLSB_Add = add;
        bus.iLSB_Dat = dat;
      end else if (junk && c <= (dropped ? mp_cyc : done)) begin
        bus.iLSB_En  = 1'b1;
        bus.iLSB_Rw  = 1'($urandom);
        bus.iLSB_Len = 3'($urandom);
        bus.iLSB_Add = $urandom;
        bus.iLSB_Dat = $urandom;
      end else begin
        bus.iLSB_En = 1'b0;
      end
      bus.iMEM_Gnt = (c < 32) ? gmask[c] : 1'b1;
      bus.iROB_Mp  = (c == mp_cyc);
      @(negedge clk);
      if (bus.oLSB_En === 1'b1) begin
        en_cnt++;
        if (en_cnt == 1) begin
          en_cyc = c;
          rdat = bus.oLSB_Dat;
        end
      end else if (bus.oLSB_Dat !== 32'h0) begin
        nz++;
      end
      if (bus.oMEM_Req === 1'b1) req_cnt++;
      if (bus.oMEM_Wr === 1'b1) begin
        if (nev < 8) begin
          ev_a[nev] = bus.oMEM_A;
          ev_d[nev] = bus.oMEM_Dout;
        end
        nev++;
      end
    end
    idle_inputs();

    if (dropped) begin
      nvec++;
      if (en_cnt !== 0) begin
        nerr++;
        $display("FAIL %s flush_no_done: got %0d pulses want 0", name, en_cnt);
      end
      nvec++;
      if (req_cnt !== mp_cyc) begin
        nerr++;
        $display("FAIL %s flush_req_cycles: got %0d want %0d", name, req_cnt, mp_cyc);
      end
    end else begin
      nvec++;
      if (en_cnt !== 1 || en_cyc !== done) begin
        nerr++;
        $display("FAIL %s done: got %0d pulses first at cycle %0d want 1 at cycle %0d",
                 name, en_cnt, en_cyc, done);
      end
      nvec++;
      if (req_cnt !== (hit ? 0 : done - 1)) begin
        nerr++;
        $display("FAIL %s req_cycles: got %0d want %0d", name, req_cnt, hit ? 0 : done - 1);
      end
      nvec++;
      if (rdat !== (rw ? 32'h0 : exp)) begin
        nerr++;
        $display("FAIL %s lsb_dat: got %h want %h", name, rdat, rw ? 32'h0 : exp);
      end
    end
    nvec++;
    if (nz !== 0) begin
      nerr++;
      $display("FAIL %s lsb_dat_idle: got %0d nonzero cycles want 0", name, nz);
    end
    nvec++;
    if (nev !== (rw ? len : 0)) begin
      nerr++;
      $display("FAIL %s write_count: got %0d want %0d", name, nev, rw ? len : 0);
    end
    if (rw && nev == len) begin
      for (int i = 0; i < len; i++) begin
        nvec++;
        if (ev_a[i] !== add + i || ev_d[i] !== dat[8*i +: 8]) begin
          nerr++;
          $display("FAIL %s write_byte%0d: got %h@%h want %h@%h", name, i, ev_d[i], ev_a[i],
                   dat[8*i +: 8], add + i);
        end
      end
    end

    if (rw) begin
      model_write(add, len, dat);
    end else if (!dropped && len == 4 && add[1:0] == 2'b00) begin
      bvalid = 1'b1;
      btag   = add[31:2];
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    en  = 1'b0;
    idle_inputs();
    bus.iLSB_En = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    nvec++;
    if ({bus.oMEM_Req, bus.oMEM_Wr, bus.oMEM_A, bus.oMEM_Dout, bus.oLSB_En, bus.oLSB_Dat} !== '0) begin
      nerr++;
      $display("FAIL reset_outputs: got req=%b wr=%b a=%h dout=%h en=%b dat=%h want all 0",
               bus.oMEM_Req, bus.oMEM_Wr, bus.oMEM_A, bus.oMEM_Dout, bus.oLSB_En, bus.oLSB_Dat);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    en  = 1'b1;
    bus.iLSB_En = 1'b0;
    @(negedge clk);
    nvec++;
    if ({bus.oMEM_Req, bus.oLSB_En} !== 2'b00) begin
      nerr++;
      $display("FAIL reset_release: got req=%b en=%b want 0 0", bus.oMEM_Req, bus.oLSB_En);
    end
    bvalid = 1'b0;
  endtask

  task automatic test_rst_mid_write;
    int en_cnt;
    en_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      #1;
      bus.iLSB_En  = (c == 0);
      bus.iLSB_Rw  = 1'b1;
      bus.iLSB_Len = LEN_W;
      bus.iLSB_Add = 32'h300;
      bus.iLSB_Dat = 32'hA1B2C3D4;
      bus.iMEM_Gnt = 1'b1;
      rst = (c == 3);
      @(negedge clk);
      if (bus.oLSB_En === 1'b1) en_cnt++;
      if (c == 3) begin
        nvec++;
        if ({bus.oMEM_Wr, bus.oMEM_A, bus.oMEM_Dout} !== {1'b1, 32'h302, 8'hB2}) begin
          nerr++;
          $display("FAIL rst_write_byte2: got wr=%b %h@%h want 1 b2@302", bus.oMEM_Wr,
                   bus.oMEM_Dout, bus.oMEM_A);
        end
      end
      if (c == 4) begin
        nvec++;
        if ({bus.oMEM_Req, bus.oMEM_Wr, bus.oMEM_A, bus.oMEM_Dout, bus.oLSB_En,
             bus.oLSB_Dat} !== '0) begin
          nerr++;
          $display("FAIL rst_mid_outputs: got req=%b wr=%b a=%h dout=%h en=%b dat=%h want 0",
                   bus.oMEM_Req, bus.oMEM_Wr, bus.oMEM_A, bus.oMEM_Dout, bus.oLSB_En,
                   bus.oLSB_Dat);
        end
      end
    end
    idle_inputs();
    nvec++;
    if (en_cnt !== 0) begin
      nerr++;
      $display("FAIL rst_mid_no_done: got %0d pulses want 0", en_cnt);
    end
    model_write(32'h300, 3, 32'hA1B2C3D4);
    bvalid = 1'b0;
  endtask

  task automatic test_enable;
    // Enable low in IDLE: a request must not be taken.
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      en = (c == 2);
      bus.iLSB_En  = (c < 2);
      bus.iLSB_Rw  = 1'b1;
      bus.iLSB_Len = LEN_B;
      bus.iLSB_Add = 32'h500;
      bus.iMEM_Gnt = 1'b1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.iLSB_En = 1'b0;
    @(negedge clk);
    nvec++;
    if (bus.oMEM_Req !== 1'b0) begin
      nerr++;
      $display("FAIL en_idle_hold: got req=%b want 0", bus.oMEM_Req);
    end
    // Accept SB 0x500, freeze two cycles, then resume.
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      en = !(c == 1 || c == 2);
      bus.iLSB_En  = (c == 0);
      bus.iLSB_Rw  = 1'b1;
      bus.iLSB_Len = LEN_B;
      bus.iLSB_Add = 32'h500;
      bus.iLSB_Dat = 32'h0000005A;
      bus.iMEM_Gnt = 1'b1;
      @(negedge clk);
      if (c == 1 || c == 2) begin
        nvec++;
        if ({bus.oMEM_Req, bus.oMEM_Wr, bus.oMEM_A, bus.oLSB_En} !== {2'b10, 32'h500, 1'b0}) begin
          nerr++;
          $display("FAIL en_freeze_c%0d: got req=%b wr=%b a=%h en=%b want 1 0 500 0", c,
                   bus.oMEM_Req, bus.oMEM_Wr, bus.oMEM_A, bus.oLSB_En);
        end
      end
      if (c == 3) begin
        nvec++;
        if ({bus.oMEM_Wr, bus.oMEM_A, bus.oMEM_Dout} !== {1'b1, 32'h500, 8'h5A}) begin
          nerr++;
          $display("FAIL en_resume_write: got wr=%b %h@%h want 1 5a@500", bus.oMEM_Wr,
                   bus.oMEM_Dout, bus.oMEM_A);
        end
      end
      if (c == 4) begin
        nvec++;
        if (bus.oLSB_En !== 1'b1) begin
          nerr++;
          $display("FAIL en_resume_done: got en=%b want 1", bus.oLSB_En);
        end
      end
    end
    en = 1'b1;
    idle_inputs();
    model_write(32'h500, 1, 32'h0000005A);
  endtask

  task automatic test_directed;
    txn(1'b1, LEN_W, 32'h100, 32'h44332211, '1, -1, 1'b0, "sw_0x100");
    txn(1'b0, LEN_W, 32'h100, 32'h0, '1, -1, 1'b0, "lw_0x100");
    txn(1'b1, LEN_H, 32'h203, 32'h0000BEEF, '1, -1, 1'b0, "sh_0x203");
    txn(1'b1, LEN_B, 32'h10, $urandom, '1, -1, 1'b0, "sb_0x10");
    txn(1'b0, LEN_B, 32'h10, 32'h0, 32'hFFFF_FFFD, -1, 1'b0, "lb_0x10_stall");
    txn(1'b0, LEN_H, 32'h20, 32'h0, '1, 2, 1'b0, "lh_flush");
    txn(1'b0, LEN_W, 32'h100, 32'h0, '1, -1, 1'b0, "lw_after_flush");
    txn(1'b0, LEN_W, 32'h40, 32'h0, '1, -1, 1'b0, "lw_0x40_a");
    txn(1'b0, LEN_W, 32'h40, 32'h0, '1, -1, 1'b0, "lw_0x40_b");
    txn(1'b1, LEN_B, 32'h42, 32'h000000C3, '1, -1, 1'b0, "sb_0x42");
    txn(1'b0, LEN_W, 32'h40, 32'h0, '1, -1, 1'b0, "lw_0x40_c");
    txn(1'b1, LEN_H, 32'h20, 32'h00001234, '1, 1, 1'b1, "sh_mp_ignored");
    txn(1'b0, 3'd3, 32'h100, 32'h0, '1, -1, 1'b0, "lx_len3");
    txn(1'b1, 3'd0, 32'h304, 32'hCAFEF00D, '1, -1, 1'b0, "sx_len0");
    txn(1'b1, LEN_W, 32'hFFFF_FFFE, 32'h89ABCDEF, '1, -1, 1'b0, "sw_wrap");
    txn(1'b0, LEN_W, 32'hFFFF_FFFE, 32'h0, '1, -1, 1'b0, "lw_wrap");
  endtask

  task automatic test_random;
    bit rw;
    int r, mp;
    logic [2:0] len_raw;
    logic [31:0] add;
    for (int n = 0; n < 60; n++) begin
      rw = 1'($urandom);
      r = int'($urandom_range(0, 9));
      len_raw = (r < 3) ? LEN_B : (r < 5) ? LEN_H : (r < 8) ? LEN_W : 3'($urandom);
      add = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) add[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) add = 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
      mp = ($urandom_range(0, 3) == 0) ? 0 : -1;
      txn(rw, len_raw, add, $urandom, $urandom | $urandom, mp, 1'($urandom), "random");
    end
    txn(1'b0, LEN_W, 32'h300, 32'h0, '1, -1, 1'b0, "lw_after_rst");
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    en  = 1'b0;
    test_reset();
    test_directed();
    test_rst_mid_write();
    txn(1'b0, LEN_W, 32'h300, 32'h0, '1, -1, 1'b0, "lw_0x300_after_rst");
    test_enable();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dcache.md
DCACHE -- requirements
Module: dcache

Interface
REQ-001 SHALL have parameter ADD_W, default 32, memory address width.
REQ-002 SHALL have port clk, input, 1, clock; rst, input, 1, reset; reset rst, synchronous, active-high; clock clk.
REQ-003 SHALL have port en, input, 1, global enable; when low, all state and outputs hold.
REQ-004 SHALL have LSB-side ports:
- iLSB_En, input, 1: request strobe.
- iLSB_Rw, input, 1: 0 is read, 1 is write.
- iLSB_Len, input, 3: byte count, 1/2/4.
- iLSB_Add, input, ADD_W: byte address.
- iLSB_Dat, input, 32: store data.
REQ-005 SHALL have ports oLSB_En, output, 1, one-cycle done pulse; oLSB_Dat, output, 32, load data, zero-extended.
REQ-006 SHALL have port iROB_Mp, input, 1, misprediction flush.
REQ-007 SHALL have memory-side ports:
- oMEM_Req, output, 1: bus request to arbiter.
- iMEM_Gnt, input, 1: bus grant for the current cycle.
- oMEM_A, output, ADD_W: byte address.
- oMEM_Wr, output, 1: write strobe.
- oMEM_Dout, output, 8: write byte.
- iMEM_Din, input, 8: read byte, valid the cycle after its address.

Function
REQ-008 SHALL implement states IDLE, XFER and DONE.
- IDLE to XFER: iLSB_En sampled high.
- XFER to DONE: last byte issued (write) or captured (read).
- DONE to IDLE: unconditionally, after one cycle.
REQ-009 SHALL latch Rw, Len, Add and Dat when iLSB_En is sampled in IDLE, and SHALL ignore iLSB_En in any other state.
REQ-010 SHALL assert oMEM_Req throughout XFER and deassert it in IDLE and DONE.
REQ-011 SHALL advance the byte index k only in XFER cycles with iMEM_Gnt=1; it SHALL drive oMEM_A=Add+k, with ADD_W-bit wrap-around.
REQ-012 For writes, each granted cycle SHALL assert oMEM_Wr=1 with oMEM_Dout=Dat[8k+7:8k]; oMEM_Wr SHALL be 0 in all other cycles.
REQ-013 For reads, iMEM_Din SHALL be captured into byte k of the result in the cycle following each granted issue, regardless of grant in the capture cycle.
REQ-014 Result bytes at or above Len SHALL be 0; byte order SHALL be little-endian.
REQ-015 With continuous grant and request in cycle 0, latency SHALL be:
- read: oLSB_En high in cycle Len+2;
- write: oLSB_En high in cycle Len+1.
REQ-016 SHALL raise oLSB_En for exactly one cycle (DONE) for both reads and writes; oLSB_Dat SHALL be valid with it and 0 otherwise.
REQ-017 SHALL stall a transfer without data loss when grant is dropped mid-transfer, resuming at the same k.
REQ-018 On iROB_Mp=1 during a read, SHALL:
- return to IDLE the next cycle;
- drop the read with no oLSB_En;
- discard any in-flight byte.
REQ-019 SHALL ignore iROB_Mp during writes; committed stores always complete.
REQ-020 SHALL treat an illegal Len (not 1, 2 or 4) as Len=4.

Reset
REQ-021 On rst, SHALL force state=IDLE, k=0, all latched fields to 0 and the read-buffer valid bit to 0.
REQ-022 On rst, all outputs SHALL be 0.
REQ-023 SHALL give rst priority over en; rst mid-transfer SHALL abandon it with no oLSB_En.

Configuration
REQ-024 Macro DCACHE_RDBUF_EN SHALL enable a one-entry word read buffer, with tag = Add[ADD_W-1:2], 32-bit data and a valid bit.
REQ-025 With DCACHE_RDBUF_EN defined, the buffer SHALL:
- fill on each completed Len=4 read with Add[1:0]=0;
- serve a Len=4 aligned read hit from IDLE with oLSB_En in cycle 1 and no memory access;
- invalidate on any write whose byte range overlaps the tagged word.
REQ-026 Without DCACHE_RDBUF_EN, every read SHALL access memory and no buffer storage SHALL exist.

Structure
REQ-027 SHALL take the state encoding, the LEN_B/LEN_H/LEN_W constants and ADD_W from the shared header/package.
REQ-028 The read buffer SHALL be sub-module dcache_rdbuf when compiled in; all other logic SHALL stay flat.

Verification
REQ-029 The bench SHALL cover these directed scenarios:
- LW at 0x100, RAM bytes 11 22 33 44, grant held -> oLSB_Dat=0x44332211 in cycle 6.
- SH at 0x203 with Dat=0xBEEF -> writes EF@0x203 then BE@0x204, oLSB_En in cycle 3.
- LB at 0x10, grant dropped during cycle 1 -> issue resumes at k=0, data 0x000000XX, oLSB_En delayed one cycle.
- LH with iROB_Mp in cycle 2 -> no oLSB_En, IDLE in cycle 3, next request accepted normally.
- With DCACHE_RDBUF_EN: LW 0x40, repeat LW 0x40 -> second completes in cycle 1 with no oMEM_Req.
- With DCACHE_RDBUF_EN: SB to 0x42, then LW 0x40 -> buffer is missed and memory is accessed.
- rst during write byte 2 -> outputs 0 the next cycle and no oLSB_En.
